// File: rtl/fifo_reader.sv
// Read-side FIFO controller: pops first-word-fall-through words and streams them out
// through a registered output word plus one skid word, keeping 1 word/cycle under ready=1.
module fifo_reader #(
    parameter int bits  = 8,
    parameter int cnt_w = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             pndng,
    input  logic [bits-1:0]  Din,
    output logic             pop,
    output logic [bits-1:0]  Dout,
    output logic             valid,
    input  logic             ready,
    output logic [cnt_w-1:0] n_out,
    output logic [1:0]       o_state
);

    // State value equals the number of words currently held.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_valid;
    logic [bits-1:0]  r_dout;
    logic [bits-1:0]  r_skid;
    logic [cnt_w-1:0] r_n_out;

    logic w_fire;
    logic w_pop;

    // Handshake: a word transfers on a rising edge where valid & ready are both 1;
    // once valid rises, Dout/valid hold until that transfer (only flush or reset cut it).
    assign w_fire = r_valid & ready;
    assign w_pop  = rst & en & pndng & ~flush & (r_state != TWO);

    assign pop     = w_pop;
    assign Dout    = r_dout;
    assign valid   = r_valid;
    assign n_out   = r_n_out;
    assign o_state = r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
            r_dout  <= '0;
            r_skid  <= '0;
            r_n_out <= '0;
        end else begin
            if (w_fire) begin
                r_n_out <= r_n_out + cnt_w'(1);
            end
            if (flush) begin
                r_state <= EMPTY;
                r_valid <= 1'b0;
            end else begin
                case (r_state)
                    EMPTY: begin
                        if (w_pop) begin
                            r_state <= ONE;
                            r_valid <= 1'b1;
                            r_dout  <= Din;
                        end
                    end
                    ONE: begin
                        if (w_fire && w_pop) begin
                            r_dout <= Din;
                        end else if (w_fire) begin
                            r_state <= EMPTY;
                            r_valid <= 1'b0;
                        end else if (w_pop) begin
                            r_state <= TWO;
                            r_skid  <= Din;
                        end
                    end
                    TWO: begin
                        // The skid word always moves up before anything newer can enter.
                        if (w_fire) begin
                            r_state <= ONE;
                            r_dout  <= r_skid;
                        end
                    end
                    default: begin
                        r_state <= EMPTY;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: directed scenarios plus a random phase, checked against a
// queue model of the FIFO contents and of the words held by the reader.
module tb_fifo_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       flush;
    logic       pndng;
    logic [7:0] Din;
    logic       ready;

    logic        pop,    pop4;
    logic [7:0]  Dout,   Dout4;
    logic        valid,  valid4;
    logic [15:0] n_out;
    logic [3:0]  n_out4;
    logic [1:0]  st,     st4;

    logic [7:0]  fifo_q[$];
    logic [7:0]  exp_q[$];
    int unsigned fired;
    int          tests;
    int          fails;

    always #5 clk = ~clk;

    fifo_reader #(.bits(8), .cnt_w(16)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .pndng(pndng), .Din(Din),
        .pop(pop), .Dout(Dout), .valid(valid), .ready(ready), .n_out(n_out),
        .o_state(st)
    );

    fifo_reader #(.bits(8), .cnt_w(4)) dut_w (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .pndng(pndng), .Din(Din),
        .pop(pop4), .Dout(Dout4), .valid(valid4), .ready(ready), .n_out(n_out4),
        .o_state(st4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: present the FIFO head, check everything mid-cycle, then advance the model.
    task automatic cycle();
        logic exp_pop;
        logic exp_fire;
        pndng = (fifo_q.size() > 0);
        Din   = pndng ? fifo_q[0] : 8'($urandom);
        @(negedge clk);
        exp_pop  = en & pndng & ~flush & (exp_q.size() < 2);
        exp_fire = (exp_q.size() > 0) & ready;
        chk("pop",    {31'd0, pop},    {31'd0, exp_pop});
        chk("pop_w",  {31'd0, pop4},   {31'd0, exp_pop});
        chk("valid",  {31'd0, valid},  {31'd0, exp_q.size() > 0});
        chk("valid_w",{31'd0, valid4}, {31'd0, exp_q.size() > 0});
        if (exp_q.size() > 0) begin
            chk("dout",   {24'd0, Dout},  {24'd0, exp_q[0]});
            chk("dout_w", {24'd0, Dout4}, {24'd0, exp_q[0]});
        end
        chk("n_out",   {16'd0, n_out},  fired % 65536);
        chk("n_out_w", {28'd0, n_out4}, fired % 16);
        chk("state",   {30'd0, st},     exp_q.size());
        @(posedge clk);
        #1;
        if (exp_fire) begin
            void'(exp_q.pop_front());
            fired++;
        end
        if (flush) begin
            exp_q.delete();
        end else if (exp_pop) begin
            exp_q.push_back(Din);
            void'(fifo_q.pop_front());
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pop"},   {31'd0, pop},   32'd0);
        chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
        chk({tag, "_dout"},  {24'd0, Dout},  32'd0);
        chk({tag, "_n_out"}, {16'd0, n_out}, 32'd0);
        chk({tag, "_n_w"},   {28'd0, n_out4}, 32'd0);
        chk({tag, "_state"}, {30'd0, st},    32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        fired = 0;
        rst   = 1'b0;
        en    = 1'b1;
        flush = 1'b0;
        ready = 1'b1;
        pndng = 1'b1;
        Din   = 8'hAA;

        // Reset with data pending: nothing may pop.
        #22;
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Streaming at full rate.
        fifo_q = '{8'h11, 8'h22, 8'h33};
        run(5);

        // Backpressure: two words taken, then held until ready rises.
        ready  = 1'b0;
        fifo_q = '{8'h11, 8'h22, 8'h33};
        run(4);
        ready = 1'b1;
        run(5);

        // Flush from the two-word state.
        ready  = 1'b0;
        fifo_q = '{8'h44, 8'h55, 8'h66, 8'h77};
        run(3);
        flush = 1'b1;
        run(1);
        flush = 1'b0;
        ready = 1'b1;
        run(4);

        // en gating: held word drains, no new pops.
        ready  = 1'b0;
        fifo_q = '{8'h88};
        run(1);
        en     = 1'b0;
        ready  = 1'b1;
        fifo_q.push_back(8'h99);
        fifo_q.push_back(8'hAB);
        run(3);
        en = 1'b1;
        run(4);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 8)
                fifo_q.push_back(8'($urandom));
            en    = ($urandom_range(0, 7) != 0);
            ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 29) == 0);
            cycle();
        end
        flush = 1'b0;
        en    = 1'b1;

        // Asynchronous reset while two words are held.
        ready  = 1'b0;
        fifo_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        run(3);
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("async_rst");
        exp_q.delete();
        fired = 0;
        @(posedge clk);
        #1;
        rst   = 1'b1;
        ready = 1'b1;
        run(4);

        // Counter wrap on the 4-bit instance: 17 fires from zero.
        fired = 0;
        rst   = 1'b0;
        #1;
        check_reset_values("wrap_rst");
        exp_q.delete();
        fifo_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 17; i++) fifo_q.push_back(8'($urandom));
        run(19);
        chk("wrap_17", {28'd0, n_out4}, 32'd1);
        chk("wrap_17_wide", {16'd0, n_out}, 32'd17);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
